// File: rtl/sysid_chk_pkg.sv
// Shared types and constants for the system-ID check master.
package sysid_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ID_REQ,
    ID_WAIT,
    TS_REQ,
    TS_WAIT,
    FIN
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_chk_timeout.sv
// Per-transaction cycle counter; expire is high during the TIMEOUT_CYC-th enabled cycle.
module sysid_chk_timeout #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/sysid_check_master.sv
// Avalon-MM read initiator that checks the system-ID slave's ID and timestamp words.
module sysid_check_master
  import sysid_chk_pkg::*;
#(
  parameter logic [31:0] EXP_ID      = 32'd0,
  parameter logic [31:0] EXP_TS      = 32'd1577004102,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  input  logic        av_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_t state, state_next;
  logic   auto_pend;
  logic   cap_id, cap_ts, set_to;
  logic   tmo_clear, tmo_enable, expire;

  sysid_chk_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expire  (expire)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Data arriving on the expiry cycle takes priority over the abort.
  always_comb begin
    state_next = state;
    cap_id     = 1'b0;
    cap_ts     = 1'b0;
    set_to     = 1'b0;
    case (state)
      IDLE: if (start || auto_pend) state_next = ID_REQ;
      ID_REQ: begin
        if (!av_waitrequest && av_readdatavalid) begin
          cap_id     = 1'b1;
          state_next = TS_REQ;
        end else if (expire) begin
          set_to     = 1'b1;
          state_next = FIN;
        end else if (!av_waitrequest) begin
          state_next = ID_WAIT;
        end
      end
      ID_WAIT: begin
        if (av_readdatavalid) begin
          cap_id     = 1'b1;
          state_next = TS_REQ;
        end else if (expire) begin
          set_to     = 1'b1;
          state_next = FIN;
        end
      end
      TS_REQ: begin
        if (!av_waitrequest && av_readdatavalid) begin
          cap_ts     = 1'b1;
          state_next = FIN;
        end else if (expire) begin
          set_to     = 1'b1;
          state_next = FIN;
        end else if (!av_waitrequest) begin
          state_next = TS_WAIT;
        end
      end
      TS_WAIT: begin
        if (av_readdatavalid) begin
          cap_ts     = 1'b1;
          state_next = FIN;
        end else if (expire) begin
          set_to     = 1'b1;
          state_next = FIN;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    av_read    = (state == ID_REQ) || (state == TS_REQ);
    av_address = (state == TS_REQ) ? ADDR_TS : ADDR_ID;
    busy       = (state != IDLE);
    done       = (state == FIN);
  end

  assign tmo_clear  = ((state_next == ID_REQ) && (state != ID_REQ)) ||
                      ((state_next == TS_REQ) && (state != TS_REQ));
  assign tmo_enable = (state == ID_REQ) || (state == ID_WAIT) ||
                      (state == TS_REQ) || (state == TS_WAIT);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      auto_pend <= AUTO_START;
      id_ok     <= 1'b0;
      ts_ok     <= 1'b0;
      timeout   <= 1'b0;
      id_value  <= '0;
      ts_value  <= '0;
    end else begin
      if ((state == IDLE) && (state_next == ID_REQ)) begin
        auto_pend <= 1'b0;
        id_ok     <= 1'b0;
        ts_ok     <= 1'b0;
        timeout   <= 1'b0;
        id_value  <= '0;
        ts_value  <= '0;
      end
      if (cap_id) begin
        id_value <= av_readdata;
        id_ok    <= (av_readdata == EXP_ID);
      end
      if (cap_ts) begin
        ts_value <= av_readdata;
        ts_ok    <= (av_readdata == EXP_TS);
      end
      if (set_to) timeout <= 1'b1;
    end
  end

endmodule
